// File: rtl/rs_pkg.sv
// Shared state type and default timing for the RS flip-flop drive controller.
package rs_pkg;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StDrvS,
        StDrvR,
        StGuard
    } drv_state_e;

    localparam int unsigned PulseWDefault = 2;
    localparam int unsigned GuardWDefault = 1;

endpackage

// File: rtl/rs_drive_ctrl.sv
// Command front-end for a gated RS flip-flop: turns single-cycle set/clear
// requests into fixed-width, mutually exclusive R/S pulses with a guard gap,
// tracks the expected latch state and flags disagreement with the fed-back Q.
module rs_drive_ctrl
    import rs_pkg::*;
#(
    parameter int unsigned PULSE_W = PulseWDefault,
    parameter int unsigned GUARD_W = GuardWDefault
) (
    input  logic Clk,
    input  logic Rst,
    input  logic SetReq,
    input  logic ClrReq,
    input  logic QFb,
    output logic Ready,
    output logic S,
    output logic R,
    output logic QExp,
    output logic Done,
    output logic Conflict,
    output logic Mismatch
);

    localparam int unsigned MaxW = (PULSE_W > GUARD_W) ? PULSE_W : GUARD_W;
    localparam int unsigned CntW = $clog2(MaxW + 1);

    localparam logic [CntW-1:0] PulseCnt = CntW'(PULSE_W);
    localparam logic [CntW-1:0] GuardCnt = CntW'(GUARD_W);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [CntW-1:0] CntTwo   = CntW'(2);

    drv_state_e      state;
    logic [CntW-1:0] cnt;
    // Set while the current guard follows a user command, so init raises no Done.
    logic            from_cmd;

    // Single FSM with every output registered alongside the state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= StInit;
            cnt      <= PulseCnt;
            from_cmd <= 1'b0;
            Ready    <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
            QExp     <= 1'b0;
            Done     <= 1'b0;
            Conflict <= 1'b0;
            Mismatch <= 1'b0;
        end else begin
            Done     <= 1'b0;
            Conflict <= 1'b0;
            unique case (state)
                StInit: begin
                    // R is still low in the first cycle out of reset: start the clear pulse.
                    if (!R) begin
                        R <= 1'b1;
                    end else if (cnt == CntOne) begin
                        R        <= 1'b0;
                        state    <= StGuard;
                        cnt      <= GuardCnt;
                        from_cmd <= 1'b0;
                    end else begin
                        cnt <= cnt - CntOne;
                    end
                end
                StIdle: begin
                    if (SetReq && ClrReq) begin
                        Conflict <= 1'b1;
                    end else if (SetReq) begin
                        state    <= StDrvS;
                        S        <= 1'b1;
                        Ready    <= 1'b0;
                        cnt      <= PulseCnt;
                        Mismatch <= 1'b0;
                    end else if (ClrReq) begin
                        state    <= StDrvR;
                        R        <= 1'b1;
                        Ready    <= 1'b0;
                        cnt      <= PulseCnt;
                        Mismatch <= 1'b0;
                    end
                end
                StDrvS, StDrvR: begin
                    if (cnt == CntOne) begin
                        state    <= StGuard;
                        S        <= 1'b0;
                        R        <= 1'b0;
                        cnt      <= GuardCnt;
                        from_cmd <= 1'b1;
                        QExp     <= (state == StDrvS);
                        // With a one-cycle guard the first guard cycle is also the last.
                        Done     <= (GuardCnt == CntOne);
                    end else begin
                        cnt <= cnt - CntOne;
                    end
                end
                StGuard: begin
                    if (cnt == CntOne) begin
                        state    <= StIdle;
                        Ready    <= 1'b1;
                        cnt      <= PulseCnt;
                        from_cmd <= 1'b0;
                        if (QFb != QExp) begin
                            Mismatch <= 1'b1;
                        end
                    end else begin
                        cnt  <= cnt - CntOne;
                        Done <= from_cmd && (cnt == CntTwo);
                    end
                end
                default: begin
                    state <= StInit;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_drive_ctrl.sv
// Self-checking bench for rs_drive_ctrl: a timeline model predicts every output
// from the cycle offset since the last accepted operation; directed literals pin it.
module tb_rs_drive_ctrl;

    localparam int PW    = 2;
    localparam int GW    = 1;
    localparam int KInit = 0;
    localparam int KSet  = 1;
    localparam int KClr  = 2;

    logic Clk    = 1'b0;
    logic Rst    = 1'b1;
    logic SetReq = 1'b0;
    logic ClrReq = 1'b0;
    logic QFb;
    logic Ready, S, R, QExp, Done, Conflict, Mismatch;

    // Environment: behavioural RS latch plus an override for fault injection.
    logic latch     = 1'b1;
    logic force_en  = 1'b0;
    logic force_val = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: cycle index, start cycle of current operation and its kind.
    int   cyc      = 0;
    int   ev_cyc   = 0;
    int   conf_cyc = -10;
    int   kind     = KInit;
    logic q_before = 1'b0;
    logic q_after  = 1'b0;
    logic m_mis    = 1'b0;
    bit   model_valid = 1'b0;

    rs_drive_ctrl #(
        .PULSE_W (PW),
        .GUARD_W (GW)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .SetReq   (SetReq),
        .ClrReq   (ClrReq),
        .QFb      (QFb),
        .Ready    (Ready),
        .S        (S),
        .R        (R),
        .QExp     (QExp),
        .Done     (Done),
        .Conflict (Conflict),
        .Mismatch (Mismatch)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (S === 1'b1) latch <= 1'b1;
        else if (R === 1'b1) latch <= 1'b0;
    end

    assign QFb = force_en ? force_val : latch;

    function automatic logic exp_q(input int k);
        return (k < PW) ? q_before : q_after;
    endfunction

    // Outputs of cycle c, packed {Ready,S,R,QExp,Done,Conflict,Mismatch}.
    function automatic logic [6:0] expected(input int c);
        int   k;
        logic e_s, e_r, e_rdy, e_done, e_conf;
        k      = c - ev_cyc;
        e_s    = (kind == KSet) && (k >= 0) && (k < PW);
        e_r    = (kind != KSet) && (k >= 0) && (k < PW);
        e_rdy  = (k >= PW + GW);
        e_done = (kind != KInit) && (k == PW + GW - 1);
        e_conf = (c == conf_cyc);
        return {e_rdy, e_s, e_r, exp_q(k), e_done, e_conf, m_mis};
    endfunction

    // Model update at each rising edge, using inputs as the DUT samples them.
    always @(posedge Clk) begin
        int k;
        k = cyc - ev_cyc;
        if (Rst) begin
            model_valid = 1'b1;
            ev_cyc      = cyc + 2;
            kind        = KInit;
            q_before    = 1'b0;
            q_after     = 1'b0;
            m_mis       = 1'b0;
            conf_cyc    = -10;
        end else if (model_valid) begin
            if (k == PW + GW - 1 && QFb != exp_q(k)) m_mis = 1'b1;
            if (k >= PW + GW) begin
                if (SetReq && ClrReq) begin
                    conf_cyc = cyc + 1;
                end else if (SetReq || ClrReq) begin
                    q_before = q_after;
                    q_after  = SetReq;
                    kind     = SetReq ? KSet : KClr;
                    ev_cyc   = cyc + 1;
                    m_mis    = 1'b0;
                end
            end
        end
        cyc = cyc + 1;
    end

    // Advance to the next falling edge and check the whole output vector.
    task automatic step();
        logic [6:0] got, want;
        @(negedge Clk);
        if (model_valid) begin
            got  = {Ready, S, R, QExp, Done, Conflict, Mismatch};
            want = expected(cyc);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL cycle %0d {Ready,S,R,QExp,Done,Conflict,Mismatch}: got %b want %b",
                         cyc, got, want);
            end
            vectors++;
            if (R === 1'b1 && S === 1'b1) begin
                miscompares++;
                $display("FAIL cycle %0d r_and_s: got R=%b S=%b want not both 1", cyc, R, S);
            end
        end
    endtask

    task automatic lit(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic wait_ready(input string name);
        int budget;
        budget = 20;
        while (Ready !== 1'b1 && budget > 0) begin
            step();
            budget--;
        end
        lit(name, Ready, 1'b1);
    endtask

    initial begin
        int ndone;

        // Reset for two edges; cycle 0 is the cycle after the last reset edge.
        step();
        step();
        Rst = 1'b0;
        lit("rst_ready", Ready, 1'b0);
        lit("rst_r", R, 1'b0);
        lit("rst_qexp", QExp, 1'b0);
        lit("rst_mismatch", Mismatch, 1'b0);
        step();
        lit("init_r_c1", R, 1'b1);
        step();
        lit("init_r_c2", R, 1'b1);
        step();
        lit("init_guard_r", R, 1'b0);
        lit("init_guard_ready", Ready, 1'b0);
        lit("init_no_done", Done, 1'b0);
        step();
        lit("init_ready_c4", Ready, 1'b1);
        lit("init_qexp", QExp, 1'b0);
        repeat (4) step();

        // Basic set: S for two cycles, Done and QExp in the guard cycle.
        SetReq = 1'b1;
        step();
        SetReq = 1'b0;
        lit("set_s_c1", S, 1'b1);
        lit("set_busy", Ready, 1'b0);
        step();
        lit("set_s_c2", S, 1'b1);
        step();
        lit("set_done", Done, 1'b1);
        lit("set_qexp", QExp, 1'b1);
        lit("set_guard_s", S, 1'b0);
        step();
        lit("set_ready", Ready, 1'b1);
        lit("set_no_mismatch", Mismatch, 1'b0);
        lit("set_done_once", Done, 1'b0);

        // Both requests while ready: Conflict pulse, nothing else moves.
        SetReq = 1'b1;
        ClrReq = 1'b1;
        step();
        SetReq = 1'b0;
        ClrReq = 1'b0;
        lit("conf_pulse", Conflict, 1'b1);
        lit("conf_ready", Ready, 1'b1);
        lit("conf_qexp", QExp, 1'b1);
        lit("conf_s", S, 1'b0);
        lit("conf_r", R, 1'b0);
        step();
        lit("conf_one_cycle", Conflict, 1'b0);

        // Redundant set with a clear arriving while busy: clear is dropped.
        SetReq = 1'b1;
        step();
        SetReq = 1'b0;
        ClrReq = 1'b1;
        step();
        ClrReq = 1'b0;
        ndone = (Done === 1'b1) ? 1 : 0;
        repeat (6) begin
            step();
            if (Done === 1'b1) ndone++;
        end
        vectors++;
        if (ndone != 1) begin
            miscompares++;
            $display("FAIL ignored_clr_done_count: got %0d want 1", ndone);
        end
        lit("ignored_clr_qexp", QExp, 1'b1);

        // Clear, then a set with QFb held low: sticky Mismatch until next accept.
        ClrReq = 1'b1;
        step();
        ClrReq = 1'b0;
        lit("clr_r", R, 1'b1);
        wait_ready("clr_ready");
        lit("clr_qexp", QExp, 1'b0);
        force_en  = 1'b1;
        force_val = 1'b0;
        SetReq    = 1'b1;
        step();
        SetReq = 1'b0;
        step();
        step();
        lit("mis_not_yet", Mismatch, 1'b0);
        step();
        lit("mis_set", Mismatch, 1'b1);
        step();
        step();
        lit("mis_sticky", Mismatch, 1'b1);
        force_en = 1'b0;
        ClrReq   = 1'b1;
        step();
        ClrReq = 1'b0;
        lit("mis_cleared", Mismatch, 1'b0);
        wait_ready("mis_ready");

        // Reset in the second DRV_S cycle: S drops on the reset edge, then INIT R.
        SetReq = 1'b1;
        step();
        SetReq = 1'b0;
        lit("mid_s_c1", S, 1'b1);
        step();
        lit("mid_s_c2", S, 1'b1);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        lit("mid_s_drop", S, 1'b0);
        lit("mid_r_low", R, 1'b0);
        lit("mid_qexp", QExp, 1'b0);
        step();
        lit("mid_init_r", R, 1'b1);
        wait_ready("mid_ready");

        // Random request stress with occasional reset.
        for (int i = 0; i < 10000; i++) begin
            Rst    = ($urandom_range(0, 199) == 0);
            SetReq = ($urandom_range(0, 2) == 0);
            ClrReq = ($urandom_range(0, 2) == 0);
            step();
        end
        Rst    = 1'b0;
        SetReq = 1'b0;
        ClrReq = 1'b0;
        wait_ready("stress_ready");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
